// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller and its ALU decoder.
// Pure declarations: no latency, no flow control.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXEC = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IEXEC  = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11,
      S_JR     = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_NOR = 6'b100111;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_JR  = 6'b001000;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_LUI = 4'b1000;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REGA   = 2'b11;

   typedef struct packed {
      logic       mem_req;
      logic       memwrite;
      logic       bytemode;
      logic       iord;
      logic       irwrite;
      logic       pcen;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       zeroextend;
      logic       disablera1;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       retire;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_alu_funct(input logic [5:0] f);
      return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
             (f == F_OR)  || (f == F_NOR) || (f == F_SLT);
   endfunction

   function automatic logic is_byte_op(input logic [5:0] o);
      return (o == OP_LB) || (o == OP_SB);
   endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// Combinational op/funct -> 4-bit alucontrol decode; zero latency, no flow control.
// Unlisted R-type functs and non-ALU opcodes fall back to ADD.
module mips_mc_aludec
   import mips_mc_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alucontrol_o
);

   always_comb begin
      alucontrol_o = ALU_ADD;
      case (op_i)
         OP_RTYPE: begin
            case (funct_i)
               F_SUB:   alucontrol_o = ALU_SUB;
               F_AND:   alucontrol_o = ALU_AND;
               F_OR:    alucontrol_o = ALU_OR;
               F_NOR:   alucontrol_o = ALU_NOR;
               F_SLT:   alucontrol_o = ALU_SLT;
               default: alucontrol_o = ALU_ADD;
            endcase
         end
         OP_ANDI:        alucontrol_o = ALU_AND;
         OP_ORI:         alucontrol_o = ALU_OR;
         OP_LUI:         alucontrol_o = ALU_LUI;
         OP_BEQ, OP_BNE: alucontrol_o = ALU_SUB;
         default:        alucontrol_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM sharing one memory port; 2-5 cycles per instruction at zero wait.
// Memory states hold while mem_ready is low; reset forces every output to 0 immediately.
module mips_mc_controller
   import mips_mc_pkg::*;
#(
   parameter int USE_MEM_READY = 1,
   parameter int ALUCTRL_W     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           op,
   input  logic [5:0]           funct,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 memwrite,
   output logic                 bytemode,
   output logic                 iord,
   output logic                 irwrite,
   output logic                 pcen,
   output logic [1:0]           pcsrc,
   output logic                 alusrca,
   output logic [1:0]           alusrcb,
   output logic                 zeroextend,
   output logic                 disableRA1,
   output logic                 regdst,
   output logic                 memtoreg,
   output logic                 regwrite,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic [3:0]           state,
   output logic                 retire,
   output logic                 illegal
);

   state_e     state_q, state_d;
   ctrl_t      ctrl, ctrl_out;
   logic [3:0] alu_sel, alu_dec;
   logic       rdy;
   logic       byte_op;

   assign rdy     = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
   assign byte_op = is_byte_op(op);

   mips_mc_aludec u_aludec (
      .op_i         (op),
      .funct_i      (funct),
      .alucontrol_o (alu_dec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      alu_sel = ALU_AND;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_req = 1'b1;
            ctrl.alusrcb = SRCB_FOUR;
            alu_sel      = ALU_ADD;
            ctrl.irwrite = rdy;
            ctrl.pcen    = rdy;
            if (rdy) state_d = S_DECODE;
         end
         S_DECODE: begin
            ctrl.alusrcb = SRCB_IMMSH;
            alu_sel      = ALU_ADD;
            state_d      = S_FETCH;
            case (op)
               OP_LW, OP_SW, OP_LB, OP_SB:       state_d = S_MEMADR;
               OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
               OP_J:                             state_d = S_JUMP;
               OP_RTYPE: begin
                  if (funct == F_JR)           state_d = S_JR;
                  else if (is_alu_funct(funct)) state_d = S_RTEXEC;
                  else                          ctrl.illegal = 1'b1;
               end
               default: ctrl.illegal = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ctrl.alusrca  = 1'b1;
            ctrl.alusrcb  = SRCB_IMM;
            ctrl.bytemode = byte_op;
            alu_sel       = ALU_ADD;
            state_d       = ((op == OP_LW) || (op == OP_LB)) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctrl.mem_req  = 1'b1;
            ctrl.iord     = 1'b1;
            ctrl.bytemode = byte_op;
            if (rdy) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.bytemode = byte_op;
            ctrl.retire   = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWR: begin
            ctrl.mem_req  = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.iord     = 1'b1;
            ctrl.bytemode = byte_op;
            ctrl.retire   = rdy;
            if (rdy) state_d = S_FETCH;
         end
         // alucontrol stays on the decoded op through writeback so the result path is stable.
         S_RTEXEC: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            alu_sel      = alu_dec;
            state_d      = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
            ctrl.retire   = 1'b1;
            alu_sel       = alu_dec;
            state_d       = S_FETCH;
         end
         S_BRANCH: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_B;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.pcen    = (op == OP_BNE) ? ~zero : zero;
            ctrl.retire  = 1'b1;
            alu_sel      = ALU_SUB;
            state_d      = S_FETCH;
         end
         S_IEXEC: begin
            ctrl.alusrca    = 1'b1;
            ctrl.alusrcb    = SRCB_IMM;
            ctrl.zeroextend = (op == OP_ANDI) || (op == OP_ORI);
            ctrl.disablera1 = (op == OP_LUI);
            alu_sel         = alu_dec;
            state_d         = S_IWB;
         end
         S_IWB: begin
            ctrl.regwrite   = 1'b1;
            ctrl.retire     = 1'b1;
            ctrl.zeroextend = (op == OP_ANDI) || (op == OP_ORI);
            ctrl.disablera1 = (op == OP_LUI);
            alu_sel         = alu_dec;
            state_d         = S_FETCH;
         end
         S_JUMP: begin
            ctrl.pcsrc  = PCSRC_JUMP;
            ctrl.pcen   = 1'b1;
            ctrl.retire = 1'b1;
            state_d     = S_FETCH;
         end
         S_JR: begin
            ctrl.pcsrc  = PCSRC_REGA;
            ctrl.pcen   = 1'b1;
            ctrl.retire = 1'b1;
            state_d     = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Gating on reset itself aborts an in-flight access in the same cycle reset rises.
   assign ctrl_out   = reset ? '0 : ctrl;
   assign alucontrol = reset ? '0 : ALUCTRL_W'(alu_sel);
   assign state      = state_q;
   assign mem_req    = ctrl_out.mem_req;
   assign memwrite   = ctrl_out.memwrite;
   assign bytemode   = ctrl_out.bytemode;
   assign iord       = ctrl_out.iord;
   assign irwrite    = ctrl_out.irwrite;
   assign pcen       = ctrl_out.pcen;
   assign pcsrc      = ctrl_out.pcsrc;
   assign alusrca    = ctrl_out.alusrca;
   assign alusrcb    = ctrl_out.alusrcb;
   assign zeroextend = ctrl_out.zeroextend;
   assign disableRA1 = ctrl_out.disablera1;
   assign regdst     = ctrl_out.regdst;
   assign memtoreg   = ctrl_out.memtoreg;
   assign regwrite   = ctrl_out.regwrite;
   assign retire     = ctrl_out.retire;
   assign illegal    = ctrl_out.illegal;

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control unit for the next-generation MIPS core. It replaces the single-cycle combinational controller with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles through one shared memory port. A ready/request handshake allows wait-stated memory. It drives the same datapath control families as before: memtoreg, regdst, regwrite, alusrc, zeroextend, disableRA1, bytemode, jump/branch and 4-bit alucontrol. It also exports state and retire status for the board LEDs.

## Interface
Parameters:
- USE_MEM_READY, 1: 1 = wait on mem_ready; 0 = memory treated as single-cycle, mem_ready ignored.
- ALUCTRL_W, 4: alucontrol width. Fixed encodings below; wider values zero-pad the MSBs.

Ports (one clock domain; reset is asynchronous and active-high):
- clk  in  1  core clock
- reset  in  1  async active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  write request (qualified by mem_req)
- bytemode  out  1  byte access (lb/sb)
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- irwrite  out  1  load IR
- pcen  out  1  PC write enable
- pcsrc  out  2  00 = ALU, 01 = ALUOut (branch), 10 = jump target, 11 = register A (jr)
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- zeroextend  out  1  immediate zero-extend
- disableRA1  out  1  force the A operand to 0 (lui)
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  writeback from MDR
- regwrite  out  1  register file write
- alucontrol  out  ALUCTRL_W  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, LUI 1000
- state  out  4  current state (LED display)
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse when an unsupported op/funct is decoded

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, lb 100000, sb 101000, beq 000100, bne 000101, addi 001000, andi 001100, ori 001101, lui 001111, j 000010.
- R-type functs: add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010, jr 001000.
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXEC 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11, JR 12. Codes 13–15 go to FETCH.
- FETCH:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, ADD, pcsrc=00.
  - irwrite and pcen assert only in the cycle mem_ready=1. That cycle advances to DECODE; otherwise stay in FETCH.
- DECODE: alusrcb=11, ADD (branch target into ALUOut), then dispatch on op/funct:
  - lw/sw/lb/sb -> MEMADR
  - R (not jr) -> RTEXEC
  - jr -> JR
  - beq/bne -> BRANCH
  - immediate ops -> IEXEC
  - j -> JUMP
  - anything else -> FETCH, with illegal=1 for that cycle.
- MEMADR: alusrca=1, alusrcb=10, ADD. Next is MEMRD (loads) or MEMWR (stores).
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0, retire=1.
- MEMWR: mem_req=1, memwrite=1, iord=1. Hold until mem_ready; retire=1 in the exit cycle.
- bytemode=1 in MEMADR/MEMRD/MEMWB/MEMWR for lb/sb.
- RTEXEC: alusrca=1, alusrcb=00, alucontrol from funct. Then ALUWB: regwrite=1, regdst=1, retire=1.
- IEXEC: alusrca=1, alusrcb=10.
  - addi: ADD. andi: AND with zeroextend. ori: OR with zeroextend. lui: LUI with disableRA1=1.
  - Then IWB: regwrite=1, regdst=0, retire=1. zeroextend/disableRA1 are held through IWB.
- BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01.
  - pcen = zero for beq, ~zero for bne.
  - retire=1.
- JUMP: pcsrc=10, pcen=1, retire=1.
- JR: pcsrc=11, pcen=1, retire=1.
- With USE_MEM_READY=0, every memory state behaves as if mem_ready=1.
- Every terminal state returns to FETCH.

## Timing
- Reset:
  - While reset=1, state=FETCH and all outputs are forced to 0, including mem_req.
  - The first edge after release performs FETCH behaviour.
  - A reset asserted mid-access (e.g. MEMRD or MEMWR) aborts the access immediately, with no write or regwrite.
- Outputs are Moore decodes of state, except irwrite/pcen in FETCH and MEMRD/MEMWR exits, which are gated by mem_ready. pcen in BRANCH depends on zero.
- Zero-wait latencies (cycles): lw/lb 5, sw/sb 4, R-type 4, imm 4, beq/bne 3, j/jr 3, illegal 2.
- Each cycle mem_ready is low inside a memory state adds exactly one cycle.
- mem_ready outside a memory state is ignored.
- op/funct are sampled in DECODE and in the execute states. The datapath IR holds them stable after FETCH.

## Structure
- Shared package `mips_mc_pkg`:
  - state enum/localparams
  - opcode and funct constants
  - alucontrol encodings
  - alusrcb/pcsrc encodings
- Natural sub-module: `mips_mc_aludec`, combinational funct/op -> alucontrol. It is reused by the datapath tests.
- Controller top: state register plus next-state/output decode.

## Test plan
- Reset held 3 cycles, mid-FETCH -> all outputs 0; after release mem_req=1, iord=0; state 0 -> 1 on mem_ready=1.
- add (op 000000, funct 100000), zero-wait -> states 0,1,6,7. ALUWB has regwrite=1, regdst=1, alucontrol=0010, retire=1.
- lw with mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, total 7 cycles, regwrite+memtoreg in MEMWB. lb repeats with bytemode=1.
- beq with zero=1 -> pcen=1, pcsrc=01, 3 cycles. bne with zero=1 -> pcen=0.
- ori (001101) -> IEXEC alucontrol=0001, zeroextend=1. lui (001111) -> alucontrol=1000, disableRA1=1.
- op 111111 -> illegal pulses in DECODE, back to FETCH. Reset asserted in MEMWR -> memwrite drops the same cycle, state=FETCH.
